// File: rtl/multi_link_if.sv
// Signal bundle between a board's control unit and its multiplayer status link.
// master = control unit / opponent-line side, slave = the link block itself.
interface multi_link_if;
  logic player_ready;
  logic player_dead;
  logic rx;
  logic tx;
  logic opponent_ready;
  logic opponent_dead;
  logic link_up;
  logic frame_err;

  modport master (
    output player_ready, player_dead, rx,
    input  tx, opponent_ready, opponent_dead, link_up, frame_err
  );

  modport slave (
    input  player_ready, player_dead, rx,
    output tx, opponent_ready, opponent_dead, link_up, frame_err
  );
endinterface

// File: rtl/multi_link.sv
// Two-board status link: periodic UART 8N1 beacon of local ready/dead on tx,
// reception and validation of the opponent's beacon on rx, with link timeout.
module multi_link #(
  parameter int CLKS_PER_BIT   = 564,
  parameter int FRAME_GAP_BITS = 20,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  multi_link_if.slave   bus
);

  localparam int CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW        = $clog2((FRAME_GAP_BITS > 8) ? FRAME_GAP_BITS : 8);
  localparam int TMO_LIMIT = TIMEOUT_FRAMES * (10 + FRAME_GAP_BITS) * CLKS_PER_BIT;
  localparam int TW        = $clog2(TMO_LIMIT + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'(FRAME_GAP_BITS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(7);
  localparam logic [TW-1:0] TMO_END   = TW'(TMO_LIMIT);
  localparam logic [TW-1:0] TMO_PRE   = TW'(TMO_LIMIT - 1);

  typedef enum logic [1:0] {TX_GAP, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  // ---------------- transmitter ----------------
  tx_state_e       tx_state, tx_state_n;
  logic [CW-1:0]   tx_cnt, tx_cnt_n;
  logic [BW-1:0]   tx_bit, tx_bit_n;
  logic [7:0]      tx_shift, tx_shift_n;
  logic            tx_n;
  logic            tx_bit_done;
  logic [7:0]      frame_byte;

  assign tx_bit_done = (tx_cnt == BIT_LAST);
  assign frame_byte  = {4'b1010, 1'b0, bus.player_dead, bus.player_ready,
                        bus.player_dead ^ bus.player_ready};

  // NOTE: non-blocking assignments for all state so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_GAP;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      bus.tx   <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      bus.tx   <= tx_n;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_cnt_n   = tx_bit_done ? '0 : tx_cnt + CW'(1);
    case (tx_state)
      TX_GAP: if (tx_bit_done) begin
        if (tx_bit == GAP_LAST) begin
          tx_state_n = TX_START;
          tx_bit_n   = '0;
          tx_shift_n = frame_byte;
        end else begin
          tx_bit_n = tx_bit + BW'(1);
        end
      end
      TX_START: if (tx_bit_done) begin
        tx_state_n = TX_DATA;
        tx_bit_n   = '0;
      end
      TX_DATA: if (tx_bit_done) begin
        if (tx_bit == DATA_LAST) begin
          tx_state_n = TX_STOP;
          tx_bit_n   = '0;
        end else begin
          tx_bit_n   = tx_bit + BW'(1);
          tx_shift_n = {1'b0, tx_shift[7:1]};
        end
      end
      TX_STOP: if (tx_bit_done) begin
        tx_state_n = TX_GAP;
        tx_bit_n   = '0;
      end
      default: tx_state_n = TX_GAP;
    endcase
    // Line level follows the next state so tx flips on the same edge as the FSM.
    tx_n = 1'b1;
    case (tx_state_n)
      TX_START: tx_n = 1'b0;
      TX_DATA:  tx_n = tx_shift_n[0];
      default:  tx_n = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  logic            rx_meta, rx_sync;
  rx_state_e       rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_bit, rx_bit_n;
  logic [7:0]      rx_data, rx_data_n;
  logic            accept, reject, frame_ok;
  logic [TW-1:0]   tmo_cnt;

  assign frame_ok = (rx_data[7:4] == 4'b1010) && !rx_data[3] && !(^rx_data);

  // Synchroniser resets to the idle-high line level so reset never fakes a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_data  <= '0;
    end else begin
      rx_meta  <= bus.rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_data  <= rx_data_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CW'(1);
    rx_bit_n   = rx_bit;
    rx_data_n  = rx_data;
    accept     = 1'b0;
    reject     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_sync) rx_state_n = RX_START;
      end
      RX_START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n  = '0;
        rx_data_n = {rx_sync, rx_data[7:1]};
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        else                rx_bit_n   = rx_bit + 3'd1;
      end
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n = '0;
        if (rx_sync) begin
          accept     = frame_ok;
          reject     = !frame_ok;
          rx_state_n = RX_IDLE;
        end else begin
          reject     = 1'b1;
          rx_state_n = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        // Re-arm only after a full bit-time of continuous idle-high line.
        if (!rx_sync)                rx_cnt_n = '0;
        else if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Opponent status and link timeout; an accept in the timeout cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt            <= '0;
      bus.link_up        <= 1'b0;
      bus.opponent_ready <= 1'b0;
      bus.opponent_dead  <= 1'b0;
      bus.frame_err      <= 1'b0;
    end else begin
      bus.frame_err <= reject;
      if (accept) begin
        tmo_cnt            <= '0;
        bus.link_up        <= 1'b1;
        bus.opponent_ready <= rx_data[1];
        bus.opponent_dead  <= rx_data[2];
      end else if (tmo_cnt != TMO_END) begin
        tmo_cnt <= tmo_cnt + TW'(1);
        if (tmo_cnt == TMO_PRE) begin
          bus.link_up        <= 1'b0;
          bus.opponent_ready <= 1'b0;
          bus.opponent_dead  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_link.sv
// Scoreboard bench for multi_link: stimulus pushes expected tx bytes and rx-side
// output events; independent monitors decode tx and watch the status outputs.
module tb_multi_link;

  localparam int CPB = 4;

  typedef struct {
    logic err;
    logic link;
    logic rdy;
    logic dead;
    int   gap;   // required cycles since previous event, -1 = don't care
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic loop;
  logic rx_drv;
  int   cyc = 0;
  int   rel_cyc = 0;
  int   tx_starts = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0] tx_q[$];
  ev_t        ev_q[$];

  multi_link_if bus();

  assign bus.rx = loop ? bus.tx : rx_drv;

  multi_link #(.CLKS_PER_BIT(CPB), .FRAME_GAP_BITS(2), .TIMEOUT_FRAMES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input logic err, input logic link, input logic rdy,
                         input logic dead, input int gap);
    ev_t e;
    e.err = err; e.link = link; e.rdy = rdy; e.dead = dead; e.gap = gap;
    ev_q.push_back(e);
  endtask

  task automatic wait_starts(input int n);
    int budget = 0;
    while (tx_starts < n && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("tx_start_wait", 32'(tx_starts >= n), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  // tx monitor: decode each frame at mid-bit, check timing and content.
  initial begin
    int         last_start = -1;
    logic [9:0] frame;
    logic       ok;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_start = -1;
      end else if (bus.tx == 1'b0) begin
        if (last_start < 0) check("tx_first_start", 32'(cyc - rel_cyc), 32'd8);
        else                check("tx_period", 32'(cyc - last_start), 32'd48);
        last_start = cyc;
        tx_starts++;
        ok    = 1'b1;
        frame = '0;
        for (int k = 1; k <= 38; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            ok = 1'b0;
            last_start = -1;
            break;
          end
          if (k == 2) frame[0] = bus.tx;
          else if (k > 2 && k < 38 && ((k - 2) % 4) == 0) frame[(k - 2) / 4] = bus.tx;
          else if (k == 38) frame[9] = bus.tx;
        end
        if (ok && tx_q.size() != 0) begin
          logic [7:0] exp_b;
          exp_b = tx_q.pop_front();
          check("tx_frame", 32'(frame), 32'({1'b1, exp_b, 1'b0}));
        end
      end
    end
  end

  // Status monitor: every frame_err pulse or output change is one event.
  initial begin
    logic [2:0] prev = '0;
    logic [2:0] cur;
    int         last_ev = 0;
    ev_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '0;
      end else begin
        cur = {bus.link_up, bus.opponent_ready, bus.opponent_dead};
        if (bus.frame_err || cur != prev) begin
          if (ev_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got err=%0b status=%03b, expected none (cycle %0d)",
                     bus.frame_err, cur, cyc);
          end else begin
            e = ev_q.pop_front();
            check("event", 32'({bus.frame_err, cur}), 32'({e.err, e.link, e.rdy, e.dead}));
            if (e.gap >= 0) check("event_gap", 32'(cyc - last_ev), 32'(e.gap));
          end
          last_ev = cyc;
          prev    = cur;
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    loop  = 1'b0;
    rx_drv = 1'b1;
    bus.player_ready = 1'b1;
    bus.player_dead  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_link_up", 32'(bus.link_up), 32'd0);
    check("rst_opp", 32'({bus.opponent_ready, bus.opponent_dead}), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);

    // 1: beacon content, first-frame gap, period, mid-frame input changes
    rel_cyc = cyc;
    rst_n = 1'b1;
    tx_q.push_back(8'hA3);
    wait_starts(1);
    repeat (10) @(negedge clk);
    bus.player_ready = 1'b0;
    bus.player_dead  = 1'b1;
    tx_q.push_back(8'hA5);
    wait_starts(2);
    repeat (10) @(negedge clk);
    bus.player_ready = 1'b1;
    bus.player_dead  = 1'b1;
    tx_q.push_back(8'hA6);
    wait_starts(3);

    // 2: loopback, link comes up once and stays stable
    repeat (42) @(negedge clk);
    loop = 1'b1;
    push_ev(1'b0, 1'b1, 1'b1, 1'b1, -1);
    wait_starts(6);
    repeat (42) @(negedge clk);
    loop = 1'b0;

    // 3: bad parity and bad sync rejected, a valid refresh in between
    push_ev(1'b1, 1'b1, 1'b1, 1'b1, -1);
    send_byte(8'hA2);
    repeat (2) @(negedge clk);
    send_byte(8'hA6);
    repeat (2) @(negedge clk);
    push_ev(1'b1, 1'b1, 1'b1, 1'b1, -1);
    send_byte(8'h53);
    repeat (2) @(negedge clk);

    // 4: accept then timeout exactly two frame periods later, then restore
    push_ev(1'b0, 1'b1, 1'b1, 1'b0, -1);
    push_ev(1'b0, 1'b0, 1'b0, 1'b0, 96);
    send_byte(8'hA3);
    repeat (110) @(negedge clk);
    push_ev(1'b0, 1'b1, 1'b1, 1'b1, -1);
    send_byte(8'hA6);

    // 5: 1-clk glitch ignored, break gives one error, re-arm needs a high bit-time
    repeat (4) @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    push_ev(1'b1, 1'b1, 1'b1, 1'b1, -1);
    push_ev(1'b0, 1'b0, 1'b0, 1'b0, -1);
    rx_drv = 1'b0;
    repeat (80) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2) @(negedge clk);
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    push_ev(1'b0, 1'b1, 1'b1, 1'b0, -1);
    push_ev(1'b0, 1'b0, 1'b0, 1'b0, 96);
    send_byte(8'hA3);
    repeat (110) @(negedge clk);

    // 6: reset in the middle of a looped frame
    n = tx_starts;
    wait_starts(n + 1);
    repeat (42) @(negedge clk);
    loop = 1'b1;
    push_ev(1'b0, 1'b1, 1'b1, 1'b1, -1);
    wait_starts(n + 3);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_tx", 32'(bus.tx), 32'd1);
    check("midframe_rst_out",
          32'({bus.link_up, bus.opponent_ready, bus.opponent_dead, bus.frame_err}), 32'd0);
    repeat (3) @(negedge clk);
    rel_cyc = cyc;
    rst_n = 1'b1;
    tx_q.push_back(8'hA6);
    push_ev(1'b0, 1'b1, 1'b1, 1'b1, -1);
    n = tx_starts;
    wait_starts(n + 1);
    repeat (50) @(negedge clk);

    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    check("event_queue_drained", 32'(ev_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
